pb_ctrl: RTL and testbench

//  Parametrised push-button input controller: synchronises NCH raw buttons, debounces each on a shared

---
 rtl/pb_pkg.sv | 21 ++
 rtl/pb_if.sv | 12 +
 rtl/pb_debounce_ch.sv | 48 ++++
 rtl/pb_ctrl.sv | 125 ++++++++++++
 tb/tb_pb_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pb_pkg.sv
// Shared constants for the push-button controller: register offsets inside
// the 4-byte I/O window and the width of the offset field.
package pb_pkg;

  // Number of low address bits that select a register inside the window.
  localparam int PB_WIN_W = 2;

  // Register offsets relative to BASE_ADDR.
  typedef enum logic [PB_WIN_W-1:0] {
    PB_OFS_STATE   = 2'd0,
    PB_OFS_PRESS   = 2'd1,
    PB_OFS_RELEASE = 2'd2,
    PB_OFS_IRQMASK = 2'd3
  } pb_ofs_e;

  // True when addr falls inside the 4-aligned window starting at base.
  function automatic logic pb_in_window(input logic [7:0] addr, input logic [7:0] base);
    return addr[7:PB_WIN_W] == base[7:PB_WIN_W];
  endfunction

endpackage

// File: rtl/pb_if.sv
// CPU I/O read/write bus seen by the push-button controller.
// The CPU side drives address, write strobe and write data; the
// controller returns combinational read data.
interface pb_if;
  logic [7:0] addr;
  logic [7:0] out;
  logic       we;
  logic [7:0] wdata;

  modport master (output addr, output we, output wdata, input out);
  modport slave  (input addr, input we, input wdata, output out);
endinterface

// File: rtl/pb_debounce_ch.sv
// One push-button channel: two-flop synchroniser, tick-sampled shift
// register and hysteresis filter. rise/fall flag the clock in which the
// filtered state is about to flip, so event bits land together with state.
module pb_debounce_ch #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic state,
  output logic rise,
  output logic fall
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] shift_q;
  logic             all_ones;
  logic             all_zeros;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // a blocking chain here would collapse the two stages into one.
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], din};
  end

  // Shift in one synchronised sample per debounce tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shift_q <= '0;
    else if (tick) shift_q <= {shift_q[DEPTH-2:0], sync_q[1]};
  end

  assign all_ones  = &shift_q;
  assign all_zeros = ~|shift_q;

  // Filtered state only moves on a full run of equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state <= 1'b0;
    else if (all_ones)  state <= 1'b1;
    else if (all_zeros) state <= 1'b0;
  end

  assign rise = all_ones  & ~state;
  assign fall = all_zeros &  state;

endmodule

// File: rtl/pb_ctrl.sv
// Push-button input controller: NCH debounced channels on a shared sample
// tick, sticky press/release event registers with write-1-to-clear, and a
// 4-byte read window on the CPU I/O bus.
// Optional feature macro: PB_IRQ_EN adds the IRQMASK register and a
// registered level interrupt; without it irq is tied low.
module pb_ctrl
  import pb_pkg::*;
#(
  parameter int         NCH       = 5,
  parameter int         TICK_DIV  = 2**24,
  parameter int         DEPTH     = 3,
  parameter logic [7:0] BASE_ADDR = 8'hf8
) (
  input  logic           clk,
  input  logic           rst_n,
  pb_if.slave            bus,
  input  logic [NCH-1:0] pb,
  output logic           irq
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]  cnt_q;
  logic           tick;
  logic [NCH-1:0] state_v;
  logic [NCH-1:0] rise_v;
  logic [NCH-1:0] fall_v;
  logic [NCH-1:0] press_q;
  logic [NCH-1:0] release_q;
  logic [NCH-1:0] clr_press;
  logic [NCH-1:0] clr_release;
  logic           in_win;
  pb_ofs_e        ofs;
  logic [7:0]     rd_data;

  // Free-running sample-tick divider; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (cnt_q == CW'(TICK_DIV - 1)) cnt_q <= '0;
    else                                 cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pb_debounce_ch #(.DEPTH(DEPTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .din   (pb[i]),
      .state (state_v[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  assign in_win = pb_in_window(bus.addr, BASE_ADDR);
  assign ofs    = pb_ofs_e'(bus.addr[PB_WIN_W-1:0]);

  // Decode write-1-to-clear masks for the event registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    clr_press   = '0;
    clr_release = '0;
    if (bus.we && in_win) begin
      if (ofs == PB_OFS_PRESS)   clr_press   = bus.wdata[NCH-1:0];
      if (ofs == PB_OFS_RELEASE) clr_release = bus.wdata[NCH-1:0];
    end
  end

  // Sticky event bits; a new edge in the same clk as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= (press_q   & ~clr_press)   | rise_v;
      release_q <= (release_q & ~clr_release) | fall_v;
    end
  end

`ifdef PB_IRQ_EN
  logic [NCH-1:0] mask_q;

  // Interrupt mask register, written whole at the IRQMASK offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       mask_q <= '0;
    else if (bus.we && in_win && ofs == PB_OFS_IRQMASK) mask_q <= bus.wdata[NCH-1:0];
  end

  // Registered level interrupt: one clk behind the event bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |((press_q | release_q) & mask_q);
  end
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; unused upper bits and out-of-window reads are 0.
  always_comb begin
    rd_data = '0;
    if (in_win) begin
      case (ofs)
        PB_OFS_STATE:   rd_data[NCH-1:0] = state_v;
        PB_OFS_PRESS:   rd_data[NCH-1:0] = press_q;
        PB_OFS_RELEASE: rd_data[NCH-1:0] = release_q;
        PB_OFS_IRQMASK: begin
`ifdef PB_IRQ_EN
          rd_data[NCH-1:0] = mask_q;
`endif
        end
        default:        rd_data = '0;
      endcase
    end
  end

  assign bus.out = rd_data;

  // Write-data bits above NCH have no destination.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.wdata};

endmodule

// File: tb/tb_pb_ctrl.sv
// Directed bench for pb_ctrl with NCH=5, TICK_DIV=4, DEPTH=3, BASE_ADDR=8'hf8.
// Expected read values are queued when a read is issued and popped when the
// bus returns data.
module tb_pb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pb = '0;
  logic       irq;

  pb_if bus ();

  pb_ctrl #(
    .NCH       (5),
    .TICK_DIV  (4),
    .DEPTH     (3),
    .BASE_ADDR (8'hf8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .pb    (pb),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a read; the expected value goes through the scoreboard queue.
  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    bus.addr = a;
    #1;
    check(tag, bus.out, exp_q.pop_front());
  endtask

  task automatic chk_irq(input logic e, input string tag);
    exp_q.push_back({7'b0, e});
    check(tag, {7'b0, irq}, exp_q.pop_front());
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pb(input logic [4:0] v);
    @(negedge clk);
    pb = v;
  endtask

  // Bounded wait for channel ch's filtered rising edge; returns at a negedge.
  task automatic wait_rise(input int ch, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dut.rise_v[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {7'b0, ok}, 8'h01);
  endtask

  initial begin
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;
    bus.we    = 1'b0;

    // 1. Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clks(1);
    rd(8'hf8, 8'h00, "rst_state");
    rd(8'hf9, 8'h00, "rst_press");
    rd(8'hfa, 8'h00, "rst_release");
    rd(8'hfb, 8'h00, "rst_mask");
    rd(8'h00, 8'h00, "rst_outside");
    chk_irq(1'b0, "rst_irq");

    // 2. Clean press and release on channel 0
    set_pb(5'b00001);
    clks(5);
    rd(8'hf8, 8'h00, "press_too_early");
    clks(15);
    rd(8'hf8, 8'h01, "press_state");
    rd(8'hf9, 8'h01, "press_event");
    rd(8'h78, 8'h00, "alias_outside");
    set_pb(5'b00000);
    clks(20);
    rd(8'hf8, 8'h00, "release_state");
    rd(8'hfa, 8'h01, "release_event");

    // 3. Short glitch on ch2 and per-tick chatter on ch3
    wr(8'hf9, 8'hff);
    wr(8'hfa, 8'hff);
    rd(8'hf9, 8'h00, "w1c_all_press");
    rd(8'hfa, 8'h00, "w1c_all_release");
    set_pb(5'b00100);
    repeat (3) @(negedge clk);
    pb = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      pb[3] = ~pb[3];
      repeat (4) @(negedge clk);
      rd(8'hf8, 8'h00, "chatter_state");
    end
    pb = 5'b00000;
    clks(20);
    rd(8'hf8, 8'h00, "glitch_state");
    rd(8'hf9, 8'h00, "glitch_press");
    rd(8'hfa, 8'h00, "glitch_release");

    // 4. W1C and set-wins
    set_pb(5'b00011);
    clks(20);
    rd(8'hf9, 8'h03, "press_two");
    wr(8'hf9, 8'h01);
    rd(8'hf9, 8'h02, "w1c_one");
    set_pb(5'b00010);
    clks(20);
    rd(8'hfa, 8'h01, "release_ch0");
    set_pb(5'b00011);
    wait_rise(0, "rise0_timeout");
    bus.addr  = 8'hf9;
    bus.wdata = 8'h01;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    rd(8'hf9, 8'h03, "set_wins");

    // 5. Interrupt path
`ifdef PB_IRQ_EN
    set_pb(5'b00001);
    clks(20);
    wr(8'hf9, 8'hff);
    wr(8'hfa, 8'hff);
    wr(8'hfb, 8'h04);
    rd(8'hfb, 8'h04, "mask_rd");
    set_pb(5'b00011);
    clks(20);
    rd(8'hf9, 8'h02, "press_ch1");
    chk_irq(1'b0, "irq_masked");
    set_pb(5'b00111);
    wait_rise(2, "rise2_timeout");
    @(posedge clk);
    #1;
    rd(8'hf9, 8'h06, "press_ch2");
    chk_irq(1'b0, "irq_lag");
    clks(1);
    chk_irq(1'b1, "irq_set");
    wr(8'hf9, 8'h04);
    rd(8'hf9, 8'h02, "w1c_ch2");
    clks(1);
    chk_irq(1'b0, "irq_clear");
`else
    set_pb(5'b00111);
    clks(20);
    rd(8'hf9, 8'h07, "press_ch2");
    chk_irq(1'b0, "irq_tied");
    wr(8'hfb, 8'h1f);
    rd(8'hfb, 8'h00, "mask_absent");
    chk_irq(1'b0, "irq_tied_after_wr");
`endif

    // 6. Asynchronous reset mid-debounce
    set_pb(5'b10000);
    clks(6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rd(8'hf8, 8'h00, "arst_state");
    rd(8'hf9, 8'h00, "arst_press");
    rd(8'hfa, 8'h00, "arst_release");
    rd(8'hfb, 8'h00, "arst_mask");
    chk_irq(1'b0, "arst_irq");
    @(negedge clk);
    rst_n = 1'b1;
    clks(10);
    rd(8'hf8, 8'h00, "requal_early");
    clks(6);
    rd(8'hf8, 8'h10, "requal_state");
    rd(8'hf9, 8'h10, "requal_press");
    chk_irq(1'b0, "requal_irq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
